// File: rtl/xadc_mux_sequencer_if.sv
// XADC conversion-control and DRP read signals seen by the mux sequencer.
// master: the sequencer side; slave: the XADC (or its model) side.
interface xadc_mux_sequencer_if;
    logic        adc_busy;
    logic        adc_eoc;
    logic        adc_drdy;
    logic [15:0] adc_do;
    logic        adc_convst;
    logic        adc_den;
    logic [6:0]  adc_daddr;

    modport master (
        input  adc_busy, adc_eoc, adc_drdy, adc_do,
        output adc_convst, adc_den, adc_daddr
    );

    modport slave (
        output adc_busy, adc_eoc, adc_drdy, adc_do,
        input  adc_convst, adc_den, adc_daddr
    );
endinterface

// File: rtl/xadc_mux_sequencer.sv
// xadc_mux_sequencer: steps an external analog mux through NUM_CH channels,
// waits for the mux to settle, runs an XADC conversion, reads the result over
// DRP and publishes a full frame with a freshness/sanity flag (valid_data).
// Build option: define XADC_AVG_EN to take four conversions per channel and
// store their truncated mean instead of a single sample.
module xadc_mux_sequencer #(
    parameter int         NUM_CH          = 2,
    parameter int         BLANK_TIME      = 1000,
    parameter int         BOOT_TIME       = 600000,
    parameter int         MAX_SAMPLE_TIME = 24000,
    parameter int         MIN_CODE        = 275,
    parameter int         GUARD_CH        = 1,
    parameter logic [6:0] DADDR           = 7'h03,
    localparam int        CH_W            = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    xadc_mux_sequencer_if.master    adc,
    output logic [CH_W-1:0]         mux_sel,
    output logic                    new_data,
    output logic [12*NUM_CH-1:0]    data,
    output logic                    valid_data,
    output logic                    timeout_err
);

    localparam int TMO_CLKS = 4096;
    localparam int CNT_TOP  = (BOOT_TIME > BLANK_TIME)
                            ? ((BOOT_TIME  > TMO_CLKS) ? BOOT_TIME  : TMO_CLKS)
                            : ((BLANK_TIME > TMO_CLKS) ? BLANK_TIME : TMO_CLKS);
    localparam int CNT_W    = $clog2(CNT_TOP + 1);
    localparam int WD_W     = $clog2(MAX_SAMPLE_TIME + 1);

    typedef enum logic [2:0] {
        BOOT, SETTLE, CONVST, WAIT_EOC, READ, WAIT_DRDY, NEXT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WD_W-1:0]  wd;
    logic             busy_p0, eoc_p0, drdy_p0;
    logic [11:0]      code_p0;
    logic [11:0]      slot [NUM_CH];
    logic             convst, den, capture, abort, mux_adv;
    logic             store_en;
    logic [11:0]      store_val;
    logic             guard_low;

    // Watchdog step: cleared by a new frame, otherwise counts up and sticks at the limit.
    function automatic logic [WD_W-1:0] wd_step(input logic [WD_W-1:0] w, input logic clr);
        if (clr)
            return '0;
        if (w == WD_W'(MAX_SAMPLE_TIME))
            return w;
        return w + 1'b1;
    endfunction

`ifdef XADC_AVG_EN
    logic [13:0] acc_p1;
    logic [1:0]  conv_idx;
    logic [13:0] sum;

    // Mean of four 12-bit codes: drop the two fractional bits of the 14-bit sum.
    function automatic logic [11:0] avg_trunc(input logic [13:0] s);
        return s[13:2];
    endfunction

    assign sum = acc_p1 + {2'b00, code_p0};
`endif

    assign adc.adc_convst = convst;
    assign adc.adc_den    = den;
    assign adc.adc_daddr  = DADDR;
    assign guard_low      = (slot[GUARD_CH] < 12'(MIN_CODE));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign data[12*k +: 12] = slot[k];
    end

    // Register the XADC status and read data; the FSM only ever looks at these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_p0 <= 1'b0;
            eoc_p0  <= 1'b0;
            drdy_p0 <= 1'b0;
            code_p0 <= '0;
        end else begin
            busy_p0 <= adc.adc_busy;
            eoc_p0  <= adc.adc_eoc;
            drdy_p0 <= adc.adc_drdy;
            code_p0 <= adc.adc_do[15:4];
        end
    end

    // State and shared boot/settle/timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode and one-cycle strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        convst    = 1'b0;
        den       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        mux_adv   = 1'b0;
        new_data  = 1'b0;
        store_en  = 1'b0;
        store_val = code_p0;
        case (state)
            BOOT: begin
                if (cnt == CNT_W'(BOOT_TIME)) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else if (busy_p0) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (busy_p0) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(BLANK_TIME)) begin
                    state_nxt = CONVST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CONVST: begin
                convst    = 1'b1;
                state_nxt = WAIT_EOC;
                cnt_nxt   = '0;
            end
            WAIT_EOC: begin
                if (eoc_p0) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TMO_CLKS - 1)) begin
                    abort     = 1'b1;
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READ: begin
                den       = 1'b1;
                state_nxt = WAIT_DRDY;
                cnt_nxt   = '0;
            end
            WAIT_DRDY: begin
                if (drdy_p0) begin
                    capture = 1'b1;
                    cnt_nxt = '0;
`ifdef XADC_AVG_EN
                    store_val = avg_trunc(sum);
                    if (conv_idx == 2'd3) begin
                        store_en  = 1'b1;
                        state_nxt = NEXT;
                    end else begin
                        state_nxt = CONVST;
                    end
`else
                    store_en  = 1'b1;
                    state_nxt = NEXT;
`endif
                end else if (cnt == CNT_W'(TMO_CLKS - 1)) begin
                    abort     = 1'b1;
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            NEXT: begin
                mux_adv   = 1'b1;
                new_data  = (mux_sel == CH_W'(NUM_CH - 1));
                state_nxt = SETTLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = BOOT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Mux channel pointer and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (mux_adv)
                mux_sel <= (mux_sel == CH_W'(NUM_CH - 1)) ? '0 : mux_sel + 1'b1;
            if (abort)
                timeout_err <= 1'b1;
        end
    end

`ifdef XADC_AVG_EN
    // Four-sample accumulator; an aborted conversion throws away the partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1   <= '0;
            conv_idx <= '0;
        end else if (abort || store_en) begin
            acc_p1   <= '0;
            conv_idx <= '0;
        end else if (capture) begin
            acc_p1   <= sum;
            conv_idx <= conv_idx + 1'b1;
        end
    end
`endif

    // Per-channel result slots, written only on a completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                slot[k] <= '0;
        end else if (store_en) begin
            for (int k = 0; k < NUM_CH; k++)
                if (mux_sel == CH_W'(k))
                    slot[k] <= store_val;
        end
    end

    // Freshness watchdog and valid flag; a low guard channel overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd         <= '0;
            valid_data <= 1'b0;
        end else begin
            wd <= wd_step(wd, new_data);
            if (guard_low)
                valid_data <= 1'b0;
            else if (new_data)
                valid_data <= 1'b1;
            else if (wd_step(wd, 1'b0) == WD_W'(MAX_SAMPLE_TIME))
                valid_data <= 1'b0;
        end
    end

endmodule
